// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the demo-song sequencer.
//   - default widths for note codes, duration fields and song length
//   - note code constants (rest / END marker)
//   - FSM state encoding
package song_sequencer_pkg;

    localparam int SONG_LEN_DEF = 8;
    localparam int NOTE_W_DEF   = 5;
    localparam int DUR_W_DEF    = 3;

    localparam logic [NOTE_W_DEF-1:0] NOTE_REST = '0;
    localparam logic [NOTE_W_DEF-1:0] NOTE_END  = '1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;

endpackage

// File: rtl/song_rom.sv
// Combinational melody ROM: addr -> {note, dur}.
// Ports:
//   addr  in   ROM address
//   note  out  note code (0 = rest, all-ones = END)
//   dur   out  duration field, value d lasts d+1 ticks
// Any address beyond the stored melody reads as END.
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter int SONG_LEN = SONG_LEN_DEF,
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int AW       = $clog2(SONG_LEN)
) (
    input  logic [AW-1:0]     addr,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  dur
);

    always_comb begin
        note = '1;
        dur  = '0;
        case (addr)
            AW'(0): begin note = NOTE_W'(1); dur = DUR_W'(1); end
            AW'(1): begin note = NOTE_W'(3); dur = DUR_W'(0); end
            AW'(2): begin note = NOTE_W'(0); dur = DUR_W'(0); end
            AW'(3): begin note = NOTE_W'(5); dur = DUR_W'(2); end
            AW'(4): begin note = NOTE_W'(8); dur = DUR_W'(0); end
            AW'(5): begin note = NOTE_W'(5); dur = DUR_W'(0); end
            AW'(6): begin note = NOTE_W'(3); dur = DUR_W'(1); end
            default: begin note = '1; dur = '0; end
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Demo-song sequencer with live keyboard pass-through.
// Steps through song_rom one duration unit per tick while playing; in idle
// the keyboard note is forwarded so the tone generator has a single source.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tick        one-cycle 2 Hz enable
//   start_p     play / toggle pause-resume pulse
//   stop_p      abort-to-idle pulse
//   key_note    live keyboard note (0 = no key)
//   note_out    registered note code
//   playing     high in PLAY
//   paused      high in PAUSE
//   pos         current ROM address
//   done        one-cycle pulse at song end
// Build option: define SONG_LOOP_EN to repeat the song until stop_p
// instead of returning to idle at END.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int SONG_LEN = SONG_LEN_DEF,
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int PW       = $clog2(SONG_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              start_p,
    input  logic              stop_p,
    input  logic [NOTE_W-1:0] key_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              playing,
    output logic              paused,
    output logic [PW-1:0]     pos,
    output logic              done
);

    state_t            state;
    logic [DUR_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              is_end;
    logic              seg_last;
    logic              end_hit;

    song_rom #(
        .SONG_LEN (SONG_LEN),
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .AW       (PW)
    ) u_rom (
        .addr (pos),
        .note (rom_note),
        .dur  (rom_dur)
    );

    // END is checked every cycle, not only on tick. Advancing past the last
    // ROM slot is folded into the same path so pos can never overflow.
    assign is_end   = (rom_note == {NOTE_W{1'b1}});
    assign seg_last = tick && (dur_cnt == rom_dur);
    assign end_hit  = is_end || (seg_last && (pos == PW'(SONG_LEN-1)));

    assign playing = (state == ST_PLAY);
    assign paused  = (state == ST_PAUSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            note_out <= '0;
            pos      <= '0;
            dur_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    note_out <= key_note;
                    pos      <= '0;
                    dur_cnt  <= '0;
                    // stop outranks start even though stop alone is a no-op here
                    if (start_p && !stop_p)
                        state <= ST_PLAY;
                end
                ST_PLAY: begin
                    note_out <= rom_note;
                    if (stop_p) begin
                        state   <= ST_IDLE;
                        pos     <= '0;
                        dur_cnt <= '0;
                    end else if (start_p) begin
                        state <= ST_PAUSE;
                    end else if (end_hit) begin
                        done     <= 1'b1;
                        note_out <= '0;
                        pos      <= '0;
                        dur_cnt  <= '0;
`ifdef SONG_LOOP_EN
                        state    <= ST_PLAY;
`else
                        state    <= ST_IDLE;
`endif
                    end else if (tick) begin
                        if (seg_last) begin
                            pos     <= pos + PW'(1);
                            dur_cnt <= '0;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    note_out <= '0;
                    if (stop_p) begin
                        state   <= ST_IDLE;
                        pos     <= '0;
                        dur_cnt <= '0;
                    end else if (start_p) begin
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pos     <= '0;
                    dur_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Consumes the one-cycle 2 Hz enable pulse from the 50 MHz clock divider and steps through a fixed demo melody, one duration unit per tick.
- Outputs a registered note code to the downstream tone generator.
- When not playing, passes live keyboard notes through, so the tone generator has a single note source.
- Start/pause and stop come from debounced single-cycle button pulses.

Parameters:
- SONG_LEN, 8, number of ROM entries; position counter width is clog2(SONG_LEN).
- NOTE_W, 5, note code width; code 0 = rest, code all-ones = END marker.
- DUR_W, 3, duration field width; field value d means d+1 ticks.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle 2 Hz enable pulse from the divider
- start_p  in  1  one-cycle pulse: play, or toggle pause/resume
- stop_p  in  1  one-cycle pulse: abort to idle
- key_note  in  NOTE_W  live keyboard note code, 0 = no key
- note_out  out  NOTE_W  registered note code to the tone generator
- playing  out  1  high in PLAY
- paused  out  1  high in PAUSE
- pos  out  clog2(SONG_LEN)  current ROM address
- done  out  1  one-cycle pulse at song end

Behaviour:
- Reset values: state IDLE; note_out, playing, paused, pos, done and dur_cnt all 0.
- States: IDLE, PLAY, PAUSE.
- IDLE:
  - note_out <= key_note every cycle (one-cycle latency).
  - tick is ignored.
  - start_p -> PLAY with pos <= 0 and dur_cnt <= 0.
- PLAY:
  - note_out <= ROM note at pos, one-cycle latency from a pos change.
  - key_note is ignored.
  - On tick: if dur_cnt == dur, then pos <= pos+1 and dur_cnt <= 0; else dur_cnt <= dur_cnt+1.
  - start_p -> PAUSE.
- PAUSE:
  - note_out <= 0.
  - pos and dur_cnt are held; tick is ignored.
  - start_p -> PLAY, resuming at the same pos and dur_cnt.
- stop_p in PLAY or PAUSE -> IDLE, pos <= 0, dur_cnt <= 0. stop_p in IDLE has no effect.
- Priority within one cycle: stop_p > start_p > tick. A tick coinciding with start_p (pause) or stop_p is dropped.
- END handling:
  - When the ROM note at pos is END while in PLAY, the next cycle has done = 1 and note_out = 0.
  - Without LOOP_EN: state -> IDLE, pos <= 0.
  - END is evaluated combinationally every cycle, independent of tick.
- Wrap: an advance from pos == SONG_LEN-1 is treated exactly as END; pos never exceeds SONG_LEN-1.
- Reset asserted mid-song returns immediately to reset values.
- Default ROM contents as (note, dur field):
  - 0:(1,1), 1:(3,0), 2:(0,0), 3:(5,2)
  - 4:(8,0), 5:(5,0), 6:(3,1), 7:END

Optional Feature:
- Macro SONG_LOOP_EN.
- When defined: at END, done still pulses, pos <= 0, dur_cnt <= 0, and the state stays PLAY, so the song repeats indefinitely until stop_p.
- When undefined: END returns to IDLE as described in Behaviour.

Decomposition:
- Shared package:
  - note code constants: NOTE_REST = 0, NOTE_END = all-ones.
  - state enum: IDLE, PLAY, PAUSE.
  - NOTE_W and DUR_W defaults.
- Sub-module song_rom: purely combinational, addr -> {note, dur}, holds the default melody.
- The FSM, counters and output register stay in song_sequencer.

Test Plan:
- Reset, then key_note = 7 in IDLE -> note_out = 7 one cycle later; tick pulses leave pos = 0.
- start_p, then 3 ticks -> note_out = 1 for ticks 0-1, then 3 after the 2nd tick, then 0 (rest) after the 3rd tick; pos = 2.
- Run 12 ticks from start -> pos reaches 7, done pulses exactly one cycle, state IDLE, note_out follows key_note again.
- Pause/resume: start_p at pos 3 with dur_cnt = 1, then 5 ticks, then start_p -> pos = 3 and dur_cnt = 1 retained; note_out = 0 while paused; next tick -> dur_cnt = 2.
- Simultaneous events: start_p and stop_p in the same PLAY cycle -> IDLE. Tick and start_p in the same cycle -> PAUSE with no advance.
- With SONG_LOOP_EN defined: run 24 ticks -> done pulses at each END, pos returns to 0, playing stays 1; stop_p -> IDLE.
